fabosc_clken_gen: RTL

Multi-channel clock-enable generator and crystal-oscillator monitor for the system-block fabric oscillator domain. It runs on the buffered RC oscillator fabric clock and produces NUM_CH independently programmable single-cycle enable strobes, so fabric logic can stay on one global clock. An optional monitor measures the crystal oscillator output, sampled as asynchronous data, against a programmable window and reports its edge count and an in-range flag.

---
 rtl/fabosc_pkg.sv | 15 +
 rtl/fabosc_div_ch.sv | 42 ++++
 rtl/fabosc_clken_gen.sv | 122 ++++++++++++
 3 files changed

// File: rtl/fabosc_pkg.sv
// rtl/fabosc_pkg.sv - shared constants and monitor state type for the fabric-oscillator clock-enable generator
package fabosc_pkg;

  localparam int NUM_CH_DEF = 4;
  localparam int DIV_W_DEF  = 16;
  localparam int WIN_W_DEF  = 16;
  localparam int SYNC_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } mon_state_t;

endpackage

// File: rtl/fabosc_div_ch.sv
// rtl/fabosc_div_ch.sv - one clock-enable channel: divisor register, down-counter and registered strobe
module fabosc_div_ch
  import fabosc_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic             load,
  input  logic [DIV_W-1:0] div_value,
  output logic             clken
);

  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_q;

  // Load wins over terminal count so a new divisor never emits a stale strobe.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_q <= '0;
      cnt_q <= '0;
      clken <= 1'b0;
    end else if (load) begin
      div_q <= div_value;
      cnt_q <= div_value;
      clken <= 1'b0;
    end else if (!en) begin
      cnt_q <= div_q;
      clken <= 1'b0;
    end else if (cnt_q == '0) begin
      cnt_q <= div_q;
      clken <= 1'b1;
    end else begin
      cnt_q <= cnt_q - DIV_ONE;
      clken <= 1'b0;
    end
  end

endmodule

// File: rtl/fabosc_clken_gen.sv
// rtl/fabosc_clken_gen.sv - NUM_CH clock-enable strobes plus optional crystal monitor
// Crystal monitor is built only when FABOSC_XTL_MON_EN is defined.
module fabosc_clken_gen
  import fabosc_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int DIV_W  = DIV_W_DEF,
  parameter int WIN_W  = WIN_W_DEF
) (
  input  logic                    CLK,
  input  logic                    RESETN,
  input  logic [NUM_CH-1:0]       CH_EN,
  input  logic [NUM_CH-1:0]       DIV_LOAD,
  input  logic [NUM_CH*DIV_W-1:0] DIV_VALUE,
  output logic [NUM_CH-1:0]       CLKEN_O,
  input  logic                    XTL_IN,
  input  logic [WIN_W-1:0]        WIN_LEN,
  input  logic [WIN_W-1:0]        XTL_MIN,
  input  logic [WIN_W-1:0]        XTL_MAX,
  output logic [WIN_W-1:0]        XTL_CNT,
  output logic                    XTL_OK,
  output logic                    XTL_VALID
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    fabosc_div_ch #(
      .DIV_W(DIV_W)
    ) u_div_ch (
      .clk      (CLK),
      .resetn   (RESETN),
      .en       (CH_EN[i]),
      .load     (DIV_LOAD[i]),
      .div_value(DIV_VALUE[i*DIV_W +: DIV_W]),
      .clken    (CLKEN_O[i])
    );
  end

`ifdef FABOSC_XTL_MON_EN

  localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);

  logic [SYNC_DEPTH-1:0] xtl_sync;
  logic                  xtl_q;
  logic                  xtl_rise;
  mon_state_t            state_q;
  mon_state_t            state_d;
  logic [WIN_W-1:0]      win_cnt;
  logic [WIN_W-1:0]      edge_cnt;

  // XTL_IN is asynchronous; only the last synchronizer stage feeds the edge detector.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      xtl_sync <= '0;
      xtl_q    <= 1'b0;
    end else begin
      xtl_sync <= {xtl_sync[SYNC_DEPTH-2:0], XTL_IN};
      xtl_q    <= xtl_sync[SYNC_DEPTH-1];
    end
  end

  assign xtl_rise = xtl_sync[SYNC_DEPTH-1] & ~xtl_q;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (WIN_LEN != '0) state_d = COUNT;
      COUNT:   if (win_cnt == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      win_cnt   <= '0;
      edge_cnt  <= '0;
      XTL_CNT   <= '0;
      XTL_OK    <= 1'b0;
      XTL_VALID <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (WIN_LEN != '0) begin
            win_cnt  <= WIN_LEN - WIN_ONE;
            edge_cnt <= '0;
          end
        end
        COUNT: begin
          if (xtl_rise && (edge_cnt != '1)) edge_cnt <= edge_cnt + WIN_ONE;
          if (win_cnt != '0) win_cnt <= win_cnt - WIN_ONE;
        end
        DONE: begin
          XTL_CNT   <= edge_cnt;
          // An inverted window (min > max) can never be satisfied.
          XTL_OK    <= (XTL_MIN <= XTL_MAX) && (edge_cnt >= XTL_MIN) && (edge_cnt <= XTL_MAX);
          XTL_VALID <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`else

  logic unused_mon;
  assign unused_mon = ^{XTL_IN, WIN_LEN, XTL_MIN, XTL_MAX};

  assign XTL_CNT   = '0;
  assign XTL_OK    = 1'b0;
  assign XTL_VALID = 1'b0;

`endif

endmodule
